// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-domain pointer/flag controller of the async FIFO (clk_a side).
// Optional FIFO_WR_OVF_EN adds overflow pulse and saturating ovf_count outputs.
module fifo_wr_ptr_ctrl #(
   parameter int ADDR_W    = 8,
   parameter int PTR_W     = ADDR_W + 1,
   parameter int AF_THRESH = 4
) (
   input  logic              clk_a,
   input  logic              rst,
   input  logic              wr_req,
   input  logic [PTR_W-1:0]  rd_ptr_sync,
`ifdef FIFO_WR_OVF_EN
   output logic              overflow,
   output logic [7:0]        ovf_count,
`endif
   output logic [PTR_W-1:0]  wr_ptr,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [PTR_W-1:0]  wr_count,
   output logic              almost_full,
   output logic              full
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [PTR_W-1:0] DEPTH_P  = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(DEPTH - AF_THRESH);

   logic [PTR_W-1:0] wr_ptr_nxt;
   logic [PTR_W-1:0] cnt_nxt;
   logic [PTR_W-1:0] cnt_clamp;

   // A count above DEPTH only arises from a corrupt read pointer; treat it as full.
   always_comb begin
      mem_we     = wr_req & ~full & ~rst;
      mem_waddr  = wr_ptr[ADDR_W-1:0];
      wr_ptr_nxt = wr_ptr + {{(PTR_W-1){1'b0}}, mem_we};
      cnt_nxt    = wr_ptr_nxt - rd_ptr_sync;
      cnt_clamp  = (cnt_nxt > DEPTH_P) ? DEPTH_P : cnt_nxt;
   end

   always_ff @(posedge clk_a) begin
      if (rst) begin
         wr_ptr      <= '0;
         wr_count    <= '0;
         almost_full <= 1'b0;
         full        <= 1'b0;
      end else begin
         wr_ptr      <= wr_ptr_nxt;
         wr_count    <= cnt_clamp;
         almost_full <= (cnt_clamp >= AF_LEVEL);
         full        <= (cnt_clamp == DEPTH_P);
      end
   end

`ifdef FIFO_WR_OVF_EN
   always_ff @(posedge clk_a) begin
      if (rst) begin
         overflow  <= 1'b0;
         ovf_count <= '0;
      end else begin
         overflow <= wr_req & full;
         if (wr_req && full && ovf_count != 8'hFF)
            ovf_count <= ovf_count + 8'd1;
      end
   end
`endif

endmodule
